pdm_word_packer: RTL and testbench
==================================

Name: pdm_word_packer

Overview:
- Downstream of the capture sequencer, which drives the RW, memory index and busy signals.
- Samples the 1-bit PDM microphone stream while RW is high and packs 32 consecutive bits into a word.
- Writes each word to the capture BRAM, using the memory index latched at the start of that word as the address.
- Also reports the ones-density of each word and a sticky overflow flag, for software and the later PCM filter.

Parameters:
- DEPTH, 46875, number of BRAM words; addresses >= DEPTH are out of range.
- FLUSH_PARTIAL, 1, 1 = write a trailing partial word zero-padded; 0 = discard it.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- rw  input  1  capture enable from the sequencer (RW).
- didx  input  16  memory index from the sequencer.
- pdm_in  input  1  raw PDM data pin; asynchronous to clk.
- bram_we  output  1  BRAM write strobe, one-cycle pulse.
- bram_addr  output  16  BRAM write address.
- bram_din  output  32  packed word; the first captured bit is at bit 31.
- ones_cnt  output  6  number of 1 bits in bram_din (0..32); valid with bram_we.
- word_cnt  output  16  count of words written since the last IDLE->FILL transition.
- overflow  output  1  sticky; set when a write is suppressed because the address is >= DEPTH.
- done  output  1  one-cycle pulse after the capture ends.

Behaviour:
- Reset: one clk edge with rst=0 clears all state.
  - Outputs go to 0 and the state machine goes to IDLE.
  - The synchroniser flops, the shift register, bit_cnt, the latched address and the ones accumulator are cleared.
  - This applies mid-capture as well; no write is issued for a partial word.
- Synchroniser: pdm_in passes through 2 flops to give pdm_s. Sampled bits lag the pin by 2 cycles.
- The state machine has three states: IDLE, FILL, FLUSH.
- IDLE:
  - If rw=1: shreg <= {31'b0, pdm_s}, bit_cnt <= 1, addr_lat <= didx, ones_acc <= pdm_s, word_cnt <= 0, overflow <= 0, next state FILL.
  - Otherwise hold.
- FILL with rw=1 (every cycle):
  - shreg <= {shreg[30:0], pdm_s}, bit_cnt <= bit_cnt + 1 (5-bit, wraps 31->0), ones_acc accumulates.
  - When the incoming bit is the 32nd (bit_cnt==31), the next cycle presents a registered write: bram_we=1, bram_din = the full word, bram_addr = addr_lat, ones_cnt = final count.
  - The next word starts in that same cycle with no lost bit: bit_cnt <= 0, ones_acc reset to 0.
  - The first bit of the next word latches addr_lat <= didx.
- FILL with rw=0 (capture end):
  - If bit_cnt==0, go to IDLE and pulse done in the next cycle.
  - Else go to FLUSH.
- FLUSH (exactly one cycle):
  - If FLUSH_PARTIAL=1, write the partial word: bram_din = shreg << (32 - bit_cnt), i.e. left-aligned with zero-filled LSBs; ones_cnt = ones_acc; bram_addr = addr_lat.
  - Then go to IDLE; done pulses in the cycle after FLUSH.
  - rw is ignored during FLUSH; bits arriving then are dropped.
- Write gating:
  - Any write with addr_lat >= DEPTH is suppressed: bram_we stays 0 and overflow <= 1, which stays set until the next IDLE->FILL transition.
  - word_cnt increments only on writes actually issued, and saturates at 16'hFFFF.
- Pulse behaviour:
  - bram_we is never high for 2 consecutive cycles.
  - done is high for exactly one cycle per capture.
  - bram_din, bram_addr and ones_cnt hold their values between writes.
- If rw rises and falls within one cycle (IDLE->FILL, then rw=0 with bit_cnt=1): FLUSH writes one bit, giving bram_din = {b,31'b0} when FLUSH_PARTIAL=1.

Test Plan:
- Reset, then rw=1 for 32 cycles with a constant pdm_in=1 and didx=5 -> after the 2-cycle sync delay, one bram_we pulse; bram_din=32'hFFFFFFFF, ones_cnt=32, bram_addr=5, word_cnt=1.
- Alternating pattern 1,0,1,0… for 64 captured bits, didx stepping 0->1 -> two writes; bram_din=32'hAAAAAAAA both times, ones_cnt=16, bram_addr=0 then 1; no gaps between words.
- rw drops after 8 captured 1-bits, FLUSH_PARTIAL=1 -> FLUSH write with bram_din=32'hFF000000, ones_cnt=8; done 1 cycle later. Repeat with FLUSH_PARTIAL=0 -> no write, done still pulses.
- didx=DEPTH (46875) at word start, 32 bits captured -> bram_we stays 0, overflow=1, word_cnt unchanged; a new rw rising edge clears overflow.
- rst=0 asserted at bit 20 of a word -> all outputs are 0 on the next cycle and no write is issued; a capture restarted after rst=1 writes a correct word at the new didx.
- Glitch case: rw high for exactly 1 cycle with pdm_s=1 -> single write 32'h80000000, ones_cnt=1, then done.

Source files
------------

// File: rtl/pdm_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : pdm_word_packer
// Description : Samples a 1-bit PDM stream while rw is high, packs 32
//               consecutive bits (first bit at bit 31) into a word and writes
//               it to the capture BRAM at the index latched at word start.
//               Reports the ones-density of each word, a sticky overflow flag
//               for out-of-range addresses and a done pulse per capture.
// Ports       : clk        - system clock
//               rst        - synchronous reset, active-low
//               rw         - capture enable from the sequencer
//               didx       - memory index from the sequencer
//               pdm_in     - raw PDM pin (asynchronous to clk)
//               bram_we    - one-cycle BRAM write strobe
//               bram_addr  - BRAM write address
//               bram_din   - packed word
//               ones_cnt   - number of 1 bits in bram_din
//               word_cnt   - words written since the last capture start
//               overflow   - sticky: a write was suppressed (addr >= DEPTH)
//               done       - one-cycle pulse after the capture ends
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_word_packer #(
    parameter int DEPTH         = 46875,
    parameter bit FLUSH_PARTIAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rw,
    input  logic [15:0] didx,
    input  logic        pdm_in,
    output logic        bram_we,
    output logic [15:0] bram_addr,
    output logic [31:0] bram_din,
    output logic [5:0]  ones_cnt,
    output logic [15:0] word_cnt,
    output logic        overflow,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] c_depth = 32'(DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sync1;
    logic        r_sync2;
    logic [31:0] r_shreg;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_addr_lat;
    logic [5:0]  r_ones_acc;

    logic [31:0] w_shreg_nxt;
    logic [4:0]  w_bit_cnt_nxt;
    logic [15:0] w_addr_nxt;
    logic [5:0]  w_ones_nxt;
    logic [31:0] w_shifted;
    logic [5:0]  w_ones_sum;
    logic [5:0]  w_flush_shamt;
    logic        w_wr_req;
    logic [31:0] w_wr_word;
    logic [5:0]  w_wr_ones;
    logic        w_done_nxt;
    logic        w_clr_stats;
    logic        w_in_range;
    logic        w_we;
    logic        w_ovf_set;

    // r_sync2 is the synchronised PDM bit (pdm_s)
    assign w_shifted     = {r_shreg[30:0], r_sync2};
    assign w_ones_sum    = r_ones_acc + {5'd0, r_sync2};
    assign w_flush_shamt = 6'd32 - {1'b0, r_bit_cnt};
    assign w_in_range    = ({16'd0, r_addr_lat} < c_depth);
    assign w_we          = w_wr_req & w_in_range;
    assign w_ovf_set     = w_wr_req & ~w_in_range;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_addr_nxt    = r_addr_lat;
        w_ones_nxt    = r_ones_acc;
        w_wr_req      = 1'b0;
        w_wr_word     = r_shreg;
        w_wr_ones     = r_ones_acc;
        w_done_nxt    = 1'b0;
        w_clr_stats   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rw) begin
                    w_shreg_nxt   = {31'd0, r_sync2};
                    w_bit_cnt_nxt = 5'd1;
                    w_addr_nxt    = didx;
                    w_ones_nxt    = {5'd0, r_sync2};
                    w_clr_stats   = 1'b1;
                    w_state_nxt   = S_FILL;
                end
            end
            S_FILL: begin
                if (rw) begin
                    w_shreg_nxt   = w_shifted;
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    // bit_cnt==0 means this is the first bit of a back-to-back word
                    if (r_bit_cnt == 5'd0) begin
                        w_addr_nxt = didx;
                    end
                    if (r_bit_cnt == 5'd31) begin
                        w_wr_req   = 1'b1;
                        w_wr_word  = w_shifted;
                        w_wr_ones  = w_ones_sum;
                        w_ones_nxt = 6'd0;
                    end else begin
                        w_ones_nxt = w_ones_sum;
                    end
                end else if (r_bit_cnt == 5'd0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    // The partial word is registered on entry so the strobe is
                    // visible during FLUSH and done follows one cycle later.
                    w_state_nxt = S_FLUSH;
                    if (FLUSH_PARTIAL) begin
                        w_wr_req  = 1'b1;
                        w_wr_word = r_shreg << w_flush_shamt;
                        w_wr_ones = r_ones_acc;
                    end
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_shreg    <= 32'd0;
            r_bit_cnt  <= 5'd0;
            r_addr_lat <= 16'd0;
            r_ones_acc <= 6'd0;
            bram_we    <= 1'b0;
            bram_addr  <= 16'd0;
            bram_din   <= 32'd0;
            ones_cnt   <= 6'd0;
            word_cnt   <= 16'd0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_sync1    <= pdm_in;
            r_sync2    <= r_sync1;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_addr_lat <= w_addr_nxt;
            r_ones_acc <= w_ones_nxt;
            bram_we    <= w_we;
            done       <= w_done_nxt;
            if (w_we) begin
                bram_addr <= r_addr_lat;
                bram_din  <= w_wr_word;
                ones_cnt  <= w_wr_ones;
            end
            if (w_clr_stats) begin
                word_cnt <= 16'd0;
            end else if (w_we && (word_cnt != 16'hFFFF)) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (w_clr_stats) begin
                overflow <= 1'b0;
            end else if (w_ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_word_packer
// Description : Directed self-checking bench for pdm_word_packer. Two
//               instances share stimulus: FLUSH_PARTIAL=1 and FLUSH_PARTIAL=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rw;
    logic [15:0] didx;
    logic        pdm_in;

    logic        bram_we,  bram_we0;
    logic [15:0] bram_addr, bram_addr0;
    logic [31:0] bram_din, bram_din0;
    logic [5:0]  ones_cnt, ones_cnt0;
    logic [15:0] word_cnt, word_cnt0;
    logic        overflow, overflow0;
    logic        done, done0;

    int checks   = 0;
    int failures = 0;

    logic [15:0] q_addr[$];
    logic [31:0] q_din[$];
    logic [5:0]  q_ones[$];
    int          q_cyc[$];
    int          cyc        = 0;
    int          done_cnt   = 0;
    int          done_cyc   = 0;
    int          done0_cnt  = 0;
    int          wr0_cnt    = 0;
    int          back2back  = 0;
    logic        prev_we    = 1'b0;
    logic [15:0] w0_addr    = 16'd0;
    logic [31:0] w0_din     = 32'd0;
    logic [5:0]  w0_ones    = 6'd0;

    pdm_word_packer #(.DEPTH(46875), .FLUSH_PARTIAL(1'b1)) dut (
        .clk(clk), .rst(rst), .rw(rw), .didx(didx), .pdm_in(pdm_in),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .ones_cnt(ones_cnt), .word_cnt(word_cnt), .overflow(overflow),
        .done(done)
    );

    pdm_word_packer #(.DEPTH(46875), .FLUSH_PARTIAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rw(rw), .didx(didx), .pdm_in(pdm_in),
        .bram_we(bram_we0), .bram_addr(bram_addr0), .bram_din(bram_din0),
        .ones_cnt(ones_cnt0), .word_cnt(word_cnt0), .overflow(overflow0),
        .done(done0)
    );

    always #5 clk = ~clk;

    // Write/done recorder, sampled 2 time units after each rising edge
    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (bram_we) begin
            q_addr.push_back(bram_addr);
            q_din.push_back(bram_din);
            q_ones.push_back(ones_cnt);
            q_cyc.push_back(cyc);
            if (prev_we) back2back++;
        end
        prev_we = bram_we;
        if (bram_we0) begin
            wr0_cnt++;
            w0_addr = bram_addr0;
            w0_din  = bram_din0;
            w0_ones = ones_cnt0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (done0) done0_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_din.delete();
        q_ones.delete();
        q_cyc.delete();
        done_cnt  = 0;
        done0_cnt = 0;
        wr0_cnt   = 0;
    endtask

    function automatic logic [31:0] din_at(input int k);
        return (q_din.size() > k) ? q_din[k] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [15:0] addr_at(input int k);
        return (q_addr.size() > k) ? q_addr[k] : 16'hDEAD;
    endfunction
    function automatic logic [5:0] ones_at(input int k);
        return (q_ones.size() > k) ? q_ones[k] : 6'h3F;
    endfunction
    function automatic int cyc_at(input int k);
        return (q_cyc.size() > k) ? q_cyc[k] : -1000;
    endfunction

    // Bit i (MSB first) is driven before edge i and captured at edge i+2,
    // so rw is held high for edges 2..n+1; didx switches for the second word.
    task automatic capture(input logic [63:0] bits, input int n,
                           input logic [15:0] d0, input logic [15:0] d1);
        for (int i = 0; i < n + 2; i++) begin
            pdm_in = (i < n) ? bits[63 - i] : 1'b0;
            rw     = (i >= 2);
            didx   = (i < 34) ? d0 : d1;
            tick();
        end
        rw     = 1'b0;
        pdm_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rw = 1'b0; didx = 16'd0; pdm_in = 1'b0;
        tick(); tick();
        chk("reset_we",       {63'd0, bram_we},  64'd0);
        chk("reset_din",      {32'd0, bram_din}, 64'd0);
        chk("reset_word_cnt", {48'd0, word_cnt}, 64'd0);
        chk("reset_ovf_done", {62'd0, overflow, done}, 64'd0);
        rst = 1'b1;
        tick();

        // All-ones word at index 5
        clear_log();
        capture({64{1'b1}}, 32, 16'd5, 16'd5);
        tick(); tick(); tick();
        chk("ones_nwr",   q_din.size(), 1);
        chk("ones_din",   din_at(0), 32'hFFFF_FFFF);
        chk("ones_cnt",   ones_at(0), 6'd32);
        chk("ones_addr",  addr_at(0), 16'd5);
        chk("ones_wcnt",  word_cnt, 16'd1);
        chk("ones_done",  done_cnt, 1);
        chk("ones_dut0",  {w0_addr, w0_din, w0_ones}, {16'd5, 32'hFFFF_FFFF, 6'd32});

        // Alternating pattern over two back-to-back words
        clear_log();
        capture({32{2'b10}}, 64, 16'd0, 16'd1);
        tick(); tick(); tick();
        chk("alt_nwr",    q_din.size(), 2);
        chk("alt_din0",   din_at(0), 32'hAAAA_AAAA);
        chk("alt_din1",   din_at(1), 32'hAAAA_AAAA);
        chk("alt_ones",   {ones_at(0), ones_at(1)}, {6'd16, 6'd16});
        chk("alt_addr",   {addr_at(0), addr_at(1)}, {16'd0, 16'd1});
        chk("alt_gap",    cyc_at(1) - cyc_at(0), 32);
        chk("alt_wcnt",   word_cnt, 16'd2);

        // Partial word of 8 ones: flushed by dut, discarded by dut0
        clear_log();
        capture({8'hFF, 56'd0}, 8, 16'd7, 16'd7);
        tick(); tick(); tick(); tick();
        chk("part_nwr",   q_din.size(), 1);
        chk("part_din",   din_at(0), 32'hFF00_0000);
        chk("part_ones",  ones_at(0), 6'd8);
        chk("part_addr",  addr_at(0), 16'd7);
        chk("part_done_lag", done_cyc - cyc_at(0), 1);
        chk("part_wcnt",  word_cnt, 16'd1);
        chk("part0_nwr",  wr0_cnt, 0);
        chk("part0_done", done0_cnt, 1);
        chk("part0_wcnt", word_cnt0, 16'd0);

        // Out-of-range index: write suppressed, overflow set
        clear_log();
        capture({64{1'b1}}, 32, 16'd46875, 16'd46875);
        tick(); tick(); tick();
        chk("ovf_nwr",    q_din.size(), 0);
        chk("ovf_flag",   {overflow, overflow0}, 2'b11);
        chk("ovf_wcnt",   word_cnt, 16'd0);
        chk("ovf_done",   done_cnt, 1);

        // One-cycle rw glitch: clears overflow, flushes a single 1 bit
        clear_log();
        pdm_in = 1'b1;
        tick(); tick();
        rw = 1'b1; didx = 16'd12;
        tick();
        rw = 1'b0;
        chk("glitch_ovf_clr", {overflow, overflow0}, 2'b00);
        tick(); tick(); tick();
        chk("glitch_nwr",  q_din.size(), 1);
        chk("glitch_din",  din_at(0), 32'h8000_0000);
        chk("glitch_ones", ones_at(0), 6'd1);
        chk("glitch_addr", addr_at(0), 16'd12);
        chk("glitch_done", {done_cnt, done0_cnt, wr0_cnt}, {32'd1, 32'd1, 32'd0});

        // Reset at bit 20 of a word, then restart at a new index
        clear_log();
        capture({64{1'b1}}, 20, 16'd3, 16'd3);
        rst = 1'b0;
        tick();
        chk("rst_outs",  {bram_we, bram_addr, bram_din, ones_cnt, done, overflow}, 0);
        chk("rst_wcnt",  word_cnt, 16'd0);
        rst = 1'b1;
        tick(); tick();
        chk("rst_nwr",   q_din.size(), 0);
        capture({64{1'b1}}, 32, 16'd9, 16'd9);
        tick(); tick(); tick();
        chk("restart_nwr",  q_din.size(), 1);
        chk("restart_din",  din_at(0), 32'hFFFF_FFFF);
        chk("restart_addr", addr_at(0), 16'd9);
        chk("restart_wcnt", word_cnt, 16'd1);

        chk("we_back2back", back2back, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
